// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: next-PC source selector and
// fetch-control state encoding.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_INC     = 2'b00,
        PC_BRANCH  = 2'b01,
        PC_RESTART = 2'b10,
        PC_RSVD    = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        PC_IDLE   = 2'b00,
        PC_RUN    = 2'b01,
        PC_HALTED = 2'b10
    } pc_state_t;

    // A non-sequential load is any accepted branch or restart.
    function automatic logic sel_is_redirect(input pc_sel_t sel);
        return (sel == PC_BRANCH) || (sel == PC_RESTART);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select; reports redirects, increment wrap and
// reserved selector encodings alongside the chosen value.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 11,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  pc_sel_t               i_pc_sel,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_pc_adder_out,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    output logic [DATA_WIDTH-1:0] o_next_pc,
    output logic                  o_redirect,
    output logic                  o_wrap,
    output logic                  o_rsvd
);

    // Source select; a reserved selector keeps the current PC.
    always_comb begin
        o_next_pc  = i_pc;
        o_redirect = sel_is_redirect(i_pc_sel);
        o_wrap     = 1'b0;
        o_rsvd     = 1'b0;
        case (i_pc_sel)
            PC_INC: begin
                o_next_pc = i_pc_adder_out;
                o_wrap    = (i_pc_adder_out == {DATA_WIDTH{1'b0}});
            end
            PC_BRANCH:  o_next_pc = i_branch_target;
            PC_RESTART: o_next_pc = RESET_VECTOR;
            PC_RSVD:    o_rsvd    = 1'b1;
            default:    o_rsvd    = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_register.sv
// Program-counter register stage: holds the PC fed to pc_adder and instruction
// memory, and gates fetch through an IDLE/RUN/HALTED controller.
module pc_register
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 11,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  stall,
    input  logic [1:0]            pc_sel,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [DATA_WIDTH-1:0] pc_adder_out,
    output logic [DATA_WIDTH-1:0] pc_adder_in,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  pc_valid,
    output logic                  redirect,
    output logic                  halted,
    output logic                  wrapped,
    output logic                  sel_error
);

    pc_state_t             r_state;
    pc_state_t             w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic                  r_redirect;
    logic                  w_redirect_nxt;
    logic                  r_halted;
    logic                  r_wrapped;
    logic                  w_wrapped_nxt;
    logic                  r_sel_error;
    logic                  w_sel_error_nxt;
    logic [DATA_WIDTH-1:0] w_mux_pc;
    logic                  w_mux_redirect;
    logic                  w_mux_wrap;
    logic                  w_mux_rsvd;

    pc_next_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_next_mux (
        .i_pc_sel        (pc_sel_t'(pc_sel)),
        .i_pc            (r_pc),
        .i_pc_adder_out  (pc_adder_out),
        .i_branch_target (branch_target),
        .o_next_pc       (w_mux_pc),
        .o_redirect      (w_mux_redirect),
        .o_wrap          (w_mux_wrap),
        .o_rsvd          (w_mux_rsvd)
    );

    // Next-state, next-PC and flag update; halt outranks stall outranks pc_sel.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_redirect_nxt  = 1'b0;
        w_wrapped_nxt   = r_wrapped;
        w_sel_error_nxt = r_sel_error;
        case (r_state)
            PC_IDLE: begin
                if (halt) begin
                    w_state_nxt = PC_HALTED;
                end else if (start) begin
                    w_state_nxt = PC_RUN;
                end else begin
                    w_state_nxt = PC_IDLE;
                end
            end
            PC_RUN: begin
                if (halt) begin
                    w_state_nxt = PC_HALTED;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_pc_nxt        = w_mux_pc;
                    w_redirect_nxt  = w_mux_redirect;
                    w_wrapped_nxt   = r_wrapped | w_mux_wrap;
                    w_sel_error_nxt = r_sel_error | w_mux_rsvd;
                end
            end
            PC_HALTED: w_state_nxt = PC_HALTED;
            default:   w_state_nxt = PC_IDLE;
        endcase
    end

    // State, PC and output flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PC_IDLE;
            r_pc        <= RESET_VECTOR;
            r_redirect  <= 1'b0;
            r_halted    <= 1'b0;
            r_wrapped   <= 1'b0;
            r_sel_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_redirect  <= w_redirect_nxt;
            r_halted    <= (w_state_nxt == PC_HALTED);
            r_wrapped   <= w_wrapped_nxt;
            r_sel_error <= w_sel_error_nxt;
        end
    end

    assign pc_out      = r_pc;
    assign pc_adder_in = r_pc;
    assign pc_valid    = (r_state == PC_RUN) && !stall && !halt;
    assign redirect    = r_redirect;
    assign halted      = r_halted;
    assign wrapped     = r_wrapped;
    assign sel_error   = r_sel_error;

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register with a behavioural PC+1 adder in the loop.
module tb_pc_register;

    localparam int W = 11;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1, start = 1'b0, halt = 1'b0, stall = 1'b0;
    logic [1:0]   pc_sel = 2'b00;
    logic [W-1:0] branch_target = '0;
    logic [W-1:0] pc_adder_out, pc_adder_in, pc_out;
    logic         pc_valid, redirect, halted, wrapped, sel_error;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_st = S_IDLE;
    int m_pc = 0;
    int m_redir = 0, m_wrap = 0, m_serr = 0;

    always #5 clk = ~clk;

    assign pc_adder_out = pc_adder_in + 11'd1;

    pc_register #(.DATA_WIDTH(W), .RESET_VECTOR(11'h000)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
        .pc_sel(pc_sel), .branch_target(branch_target), .pc_adder_out(pc_adder_out),
        .pc_adder_in(pc_adder_in), .pc_out(pc_out), .pc_valid(pc_valid),
        .redirect(redirect), .halted(halted), .wrapped(wrapped), .sel_error(sel_error)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the spec's rules.
    task automatic model_edge(input logic rs, st, hl, sl, input logic [1:0] sel, input int tgt);
        if (rs) begin
            m_st = S_IDLE; m_pc = 0; m_redir = 0; m_wrap = 0; m_serr = 0;
        end else begin
            m_redir = 0;
            if (m_st == S_IDLE) begin
                if (hl) m_st = S_HALT;
                else if (st) m_st = S_RUN;
            end else if (m_st == S_RUN) begin
                if (hl) m_st = S_HALT;
                else if (!sl) begin
                    if (sel == 2'd0) begin
                        m_pc = (m_pc + 1) % 2048;
                        if (m_pc == 0) m_wrap = 1;
                    end else if (sel == 2'd1) begin
                        m_pc = tgt; m_redir = 1;
                    end else if (sel == 2'd2) begin
                        m_pc = 0; m_redir = 1;
                    end else begin
                        m_serr = 1;
                    end
                end
            end
        end
    endtask

    // One cycle: drive, check pc_valid before the edge, check registers after it.
    task automatic step(input logic rs, st, hl, sl, input logic [1:0] sel, input logic [W-1:0] tgt);
        reset = rs; start = st; halt = hl; stall = sl; pc_sel = sel; branch_target = tgt;
        #1;
        chk("pc_valid", int'(pc_valid), int'(m_st == S_RUN && !sl && !hl));
        @(posedge clk);
        model_edge(rs, st, hl, sl, sel, int'(tgt));
        #1;
        chk("pc_out", int'(pc_out), m_pc);
        chk("pc_adder_in", int'(pc_adder_in), m_pc);
        chk("redirect", int'(redirect), m_redir);
        chk("halted", int'(halted), int'(m_st == S_HALT));
        chk("wrapped", int'(wrapped), m_wrap);
        chk("sel_error", int'(sel_error), m_serr);
    endtask

    typedef struct {
        logic rs, st, hl, sl;
        logic [1:0] sel;
        logic [W-1:0] tgt;
        logic [W-1:0] exp_pc;
        logic exp_redir;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 11'h000, 11'h000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h001, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h002, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h003, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h004, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h005, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 11'h200, 11'h200, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h201, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000, 11'h202, 1'b0};

        repeat (2) @(posedge clk);
        #1;

        // Reset, start, increments and a branch against fixed expectations
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rs, vecs[i].st, vecs[i].hl, vecs[i].sl, vecs[i].sel, vecs[i].tgt);
            chk("vec_pc", int'(pc_out), int'(vecs[i].exp_pc));
            chk("vec_redirect", int'(redirect), int'(vecs[i].exp_redir));
        end

        // Stall holds PC and suppresses a pending branch until it drops
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 11'h007);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 11'h123);
            chk("stall_pc", int'(pc_out), 7);
            chk("stall_redirect", int'(redirect), 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 11'h123);
        chk("after_stall_pc", int'(pc_out), 11'h123);

        // Increment from all-ones wraps to zero; wrapped is sticky
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 11'h7FF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        chk("wrap_pc", int'(pc_out), 0);
        chk("wrap_flag", int'(wrapped), 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        chk("wrap_sticky", int'(wrapped), 1);

        // Halt beats a same-cycle branch; HALTED ignores everything but reset
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 11'h3AA);
        chk("halt_pc", int'(pc_out), 5);
        chk("halt_flag", int'(halted), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 11'h155);
        chk("halted_frozen", int'(pc_out), 5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        chk("halt_reset_pc", int'(pc_out), 0);
        chk("halt_reset_flag", int'(halted), 0);

        // Reserved selector holds PC and sets sel_error; reset mid-RUN clears it
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 11'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 11'h000);
        chk("rsvd_pc", int'(pc_out), 2);
        chk("rsvd_flag", int'(sel_error), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 11'h000);
        chk("restart_redirect", int'(redirect), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 11'h000);
        chk("reset_sel_error", int'(sel_error), 0);
        chk("reset_wrapped", int'(wrapped), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
